// File: rtl/cache_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cache_mem_bridge
// Brief    : Queues one-cycle cache request pulses and replays each as a
//            req/gnt/rvalid bus handshake with a per-transaction timeout.
// Revision : 1.0 - initial release
// ============================================================================
module cache_mem_bridge #(
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cache_addr_i,
    input  logic [31:0] cache_wdata_i,
    input  logic        cache_we_i,
    input  logic [3:0]  cache_be_i,
    input  logic        cache_req_i,
    output logic [31:0] cache_rdata_o,
    output logic        cache_rvalid_o,
    output logic        cache_busy_o,
    output logic        cache_error_o,
    output logic        ovf_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic        mem_req_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic        mem_error_i
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [31:0]   fifo_addr  [DEPTH];
    logic [31:0]   fifo_wdata [DEPTH];
    logic          fifo_we    [DEPTH];
    logic [3:0]    fifo_be    [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [7:0]    to_cnt;
    logic          timeout_hit;
    logic          rsp_err;
    logic          push;
    logic          pop;
    logic          bus_active;

    assign cache_busy_o = (count == FULL);
    assign push         = cache_req_i && !cache_busy_o;
    assign pop          = (state == S_IDLE) && (count != '0);
    assign bus_active   = (state == S_REQ) || (state == S_WAIT);
    assign timeout_hit  = (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr]  <= cache_addr_i;
            fifo_wdata[wr_ptr] <= cache_wdata_i;
            fifo_we[wr_ptr]    <= cache_we_i;
            fifo_be[wr_ptr]    <= cache_be_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf_o  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (cache_req_i && cache_busy_o) ovf_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Timeout beats a same-cycle grant; a real rvalid beats a same-cycle timeout.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (count != '0) state_nx = S_REQ;
            S_REQ: begin
                if (timeout_hit)    state_nx = S_RESP;
                else if (mem_gnt_i) state_nx = S_WAIT;
            end
            S_WAIT: if (mem_rvalid_i || timeout_hit) state_nx = S_RESP;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req_o      = (state == S_REQ);
        cache_rvalid_o = (state == S_RESP) && !mem_we_o;
        cache_error_o  = (state == S_RESP) && rsp_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            mem_we_o      <= 1'b0;
            mem_be_o      <= '0;
            to_cnt        <= '0;
            rsp_err       <= 1'b0;
            cache_rdata_o <= '0;
        end else begin
            if (pop) begin
                mem_addr_o  <= fifo_addr[rd_ptr];
                mem_wdata_o <= fifo_wdata[rd_ptr];
                mem_we_o    <= fifo_we[rd_ptr];
                mem_be_o    <= fifo_we[rd_ptr] ? fifo_be[rd_ptr] : 4'hF;
                to_cnt      <= '0;
            end else if (bus_active) begin
                to_cnt <= to_cnt + 8'd1;
            end
            // Read data is only overwritten by read responses, so it holds across writes.
            if (state == S_WAIT && mem_rvalid_i) begin
                rsp_err <= mem_error_i;
                if (!mem_we_o) cache_rdata_o <= mem_rdata_i;
            end else if (bus_active && timeout_hit) begin
                rsp_err <= 1'b1;
                if (!mem_we_o) cache_rdata_o <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_mem_bridge
// Brief    : Cycle-based bench: scripted and random cache traffic against a
//            queue-based reference model and a scripted bus slave.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_bridge;

    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cache_addr_i = '0;
    logic [31:0] cache_wdata_i = '0;
    logic        cache_we_i = 1'b0;
    logic [3:0]  cache_be_i = '0;
    logic        cache_req_i = 1'b0;
    logic [31:0] cache_rdata_o;
    logic        cache_rvalid_o;
    logic        cache_busy_o;
    logic        cache_error_o;
    logic        ovf_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic        mem_req_o;
    logic [31:0] mem_rdata_i = '0;
    logic        mem_gnt_i = 1'b0;
    logic        mem_rvalid_i = 1'b0;
    logic        mem_error_i = 1'b0;

    cache_mem_bridge #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cache_addr_i(cache_addr_i), .cache_wdata_i(cache_wdata_i),
        .cache_we_i(cache_we_i), .cache_be_i(cache_be_i), .cache_req_i(cache_req_i),
        .cache_rdata_o(cache_rdata_o), .cache_rvalid_o(cache_rvalid_o),
        .cache_busy_o(cache_busy_o), .cache_error_o(cache_error_o), .ovf_o(ovf_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_req_o(mem_req_o), .mem_rdata_i(mem_rdata_i),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_error_i(mem_error_i)
    );

    always #5 clk = ~clk;

    // A queued request together with how the bus slave will answer it.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  be;
        int          gdly;
        int          rdly;
        bit          dead_g;
        bit          dead_r;
        logic        err;
        logic [31:0] rdata;
        int          push;
    } req_t;

    typedef struct {
        int          due;
        logic        rv;
        logic        err;
        logic [31:0] data;
    } resp_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    req_t        ref_q[$];
    resp_t       resp_q[$];
    req_t        cur;
    bit          active = 1'b0;
    bit          in_wait = 1'b0;
    int          req_cnt, wait_cnt, tot;
    int          last_l = -100;
    int          late_rv_cyc = -1;
    bit          rst_pending = 1'b1;
    bit          exp_ovf = 1'b0;
    logic [31:0] exp_rdata = '0;
    req_t        none;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic [31:0] w, input logic we,
                                input logic [3:0] be, input int gd, input int rd,
                                input bit dg, input bit dr, input logic err,
                                input logic [31:0] data);
        req_t r;
        r.addr = a; r.wdata = w; r.we = we; r.be = be; r.gdly = gd; r.rdly = rd;
        r.dead_g = dg; r.dead_r = dr; r.err = err; r.rdata = data; r.push = 0;
        return r;
    endfunction

    function automatic req_t rand_req();
        int kind = int'($urandom_range(0, 19));
        return mk($urandom, $urandom, 1'($urandom), 4'($urandom),
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  kind == 0, kind == 1, ($urandom_range(0, 7) == 0), $urandom);
    endfunction

    // Transaction ends at bus cycle `cyc`; the cache-side response is due next cycle.
    task automatic finish_txn(input logic err, input logic [31:0] data);
        resp_t rs;
        rs.due = cyc + 1; rs.rv = !cur.we; rs.err = err; rs.data = cur.we ? '0 : data;
        if (rs.rv || rs.err) resp_q.push_back(rs);
        active = 1'b0;
        last_l = cyc;
    endtask

    task automatic step(input bit rst_now, input bit pulse, input req_t r);
        req_t  nr;
        resp_t rs;
        @(posedge clk);
        #1;
        cyc++;
        reset = 1'b0;
        if (rst_pending) begin
            ref_q.delete(); resp_q.delete();
            active = 1'b0; last_l = -100; exp_ovf = 1'b0; exp_rdata = '0;
            late_rv_cyc = cyc + 1;
            check("rst_mem_addr", mem_addr_o, 32'h0);
            check("rst_mem_wdata", mem_wdata_o, 32'h0);
            check("rst_mem_we", {31'h0, mem_we_o}, 32'h0);
            check("rst_mem_be", {28'h0, mem_be_o}, 32'h0);
            check("rst_rdata", cache_rdata_o, 32'h0);
            rst_pending = 1'b0;
        end
        if (rst_now) begin
            reset = 1'b1;
            rst_pending = 1'b1;
        end
        cache_req_i = 1'b0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_error_i = 1'b0; mem_rdata_i = $urandom;

        if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
            rs = resp_q.pop_front();
            check("resp_rvalid", {31'h0, cache_rvalid_o}, {31'h0, rs.rv});
            check("resp_error", {31'h0, cache_error_o}, {31'h0, rs.err});
            if (rs.rv) exp_rdata = rs.data;
        end else begin
            check("no_rvalid", {31'h0, cache_rvalid_o}, 32'h0);
            check("no_error", {31'h0, cache_error_o}, 32'h0);
        end
        check("rdata_hold", cache_rdata_o, exp_rdata);

        if (!active && ref_q.size() > 0 &&
            cyc >= ((ref_q[0].push + 2 > last_l + 3) ? ref_q[0].push + 2 : last_l + 3)) begin
            cur = ref_q.pop_front();
            active = 1'b1; in_wait = 1'b0; req_cnt = 0; wait_cnt = 0; tot = 0;
        end
        check("busy", {31'h0, cache_busy_o}, {31'h0, ref_q.size() == DEPTH});
        check("ovf", {31'h0, ovf_o}, {31'h0, exp_ovf});

        if (active) begin
            check("mem_req", {31'h0, mem_req_o}, {31'h0, !in_wait});
            check("mem_addr", mem_addr_o, cur.addr);
            check("mem_wdata", mem_wdata_o, cur.wdata);
            check("mem_we", {31'h0, mem_we_o}, {31'h0, cur.we});
            check("mem_be", {28'h0, mem_be_o}, {28'h0, cur.we ? cur.be : 4'hF});
            tot++;
            if (!in_wait) begin
                req_cnt++;
                if ($urandom_range(0, 3) == 0) begin
                    mem_rvalid_i = 1'b1; mem_error_i = 1'($urandom);
                end
                if (tot == TIMEOUT) begin
                    finish_txn(1'b1, 32'h0);
                    late_rv_cyc = cyc + 1;
                end else if (!cur.dead_g && req_cnt > cur.gdly) begin
                    mem_gnt_i = 1'b1;
                    in_wait = 1'b1;
                end
            end else begin
                wait_cnt++;
                if ($urandom_range(0, 3) == 0) mem_gnt_i = 1'b1;
                if (!cur.dead_r && wait_cnt > cur.rdly) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = cur.rdata; mem_error_i = cur.err;
                    finish_txn(cur.err, cur.rdata);
                end else if (tot == TIMEOUT) begin
                    finish_txn(1'b1, 32'h0);
                    late_rv_cyc = cyc + 1;
                end
            end
        end else begin
            check("mem_req_idle", {31'h0, mem_req_o}, 32'h0);
            if ($urandom_range(0, 3) == 0) mem_gnt_i = 1'b1;
            if (cyc == late_rv_cyc || $urandom_range(0, 3) == 0) begin
                mem_rvalid_i = 1'b1; mem_error_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;
            end
        end

        if (pulse) begin
            cache_req_i = 1'b1;
            cache_addr_i = r.addr; cache_wdata_i = r.wdata;
            cache_we_i = r.we; cache_be_i = r.be;
            if (ref_q.size() == DEPTH) begin
                exp_ovf = 1'b1;
            end else begin
                nr = r;
                nr.push = cyc;
                ref_q.push_back(nr);
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, none);
    endtask

    initial begin
        bit found;
        none = mk('0, '0, 1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, none);
        step(1'b1, 1'b0, none);
        idle(3);

        // Single read, immediate grant and response
        step(1'b0, 1'b1, mk(32'h104, 32'h0, 1'b0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D));
        idle(8);
        // Posted write, grant after three stalled cycles
        step(1'b0, 1'b1, mk(32'h200, 32'h11223344, 1'b1, 4'b0101, 3, 1, 1'b0, 1'b0, 1'b0, '0));
        idle(10);
        // FIFO full: one long transaction on the bus, then three back-to-back pulses
        step(1'b0, 1'b1, mk(32'h300, 32'hA, 1'b0, 4'h0, 6, 0, 1'b0, 1'b0, 1'b0, 32'h1111));
        idle(3);
        step(1'b0, 1'b1, mk(32'h304, 32'hB, 1'b1, 4'h3, 0, 0, 1'b0, 1'b0, 1'b0, '0));
        step(1'b0, 1'b1, mk(32'h308, 32'hC, 1'b0, 4'h0, 1, 1, 1'b0, 1'b0, 1'b0, 32'h2222));
        step(1'b0, 1'b1, mk(32'h30C, 32'hD, 1'b0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h3333));
        idle(25);
        // Timeout on a never-granted read
        step(1'b0, 1'b1, mk(32'h400, 32'h0, 1'b0, 4'h0, 0, 0, 1'b1, 1'b0, 1'b0, '0));
        idle(14);
        // Bus error on a read
        step(1'b0, 1'b1, mk(32'h500, 32'h0, 1'b0, 4'h0, 1, 0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF));
        idle(8);
        // Reset while in WAIT with a second entry queued
        step(1'b0, 1'b1, mk(32'h600, 32'h0, 1'b0, 4'h0, 0, 0, 1'b0, 1'b1, 1'b0, '0));
        step(1'b0, 1'b1, mk(32'h604, 32'h0, 1'b0, 4'h0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h4444));
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (active && in_wait && ref_q.size() > 0) found = 1'b1;
            else step(1'b0, 1'b0, none);
        end
        check("reach_wait", {31'h0, found}, 32'h1);
        step(1'b1, 1'b0, none);
        idle(12);

        // Random traffic
        for (int i = 0; i < 700; i++) begin
            if (ref_q.size() < DEPTH ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0))
                step(1'b0, 1'b1, rand_req());
            else
                step(1'b0, 1'b0, none);
        end
        idle(3 * TIMEOUT + 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
